// File: rtl/mau_pkg.sv
// Shared constants for the multiply-accumulate unit: opcodes, readback selects
// and status byte layout.
package mau_pkg;

   localparam int unsigned ACC_W = 24;

   // Command opcodes carried on uio_in[2:0]
   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_LDA  = 3'd1;
   localparam logic [2:0] OP_LDB  = 3'd2;
   localparam logic [2:0] OP_MUL  = 3'd3;
   localparam logic [2:0] OP_MAC  = 3'd4;
   localparam logic [2:0] OP_MSUB = 3'd5;
   localparam logic [2:0] OP_CLR  = 3'd6;
   localparam logic [2:0] OP_MACI = 3'd7;

   // Readback selects carried on uio_in[5:4]
   localparam logic [1:0] SEL_B0   = 2'd0;
   localparam logic [1:0] SEL_B1   = 2'd1;
   localparam logic [1:0] SEL_B2   = 2'd2;
   localparam logic [1:0] SEL_STAT = 2'd3;

   // Bit positions inside the status byte
   localparam int unsigned STAT_OVF  = 7;
   localparam int unsigned STAT_ZERO = 6;
   localparam int unsigned STAT_NEG  = 5;

endpackage

// File: rtl/mau_mac_unit.sv
// Combinational signed multiply-accumulate datapath: acc +/- a*b with
// two's-complement overflow detection on the 24-bit result.
module mau_mac_unit
   import mau_pkg::*;
(
   input  logic [ACC_W-1:0] acc_i,
   input  logic [7:0]       a_i,
   input  logic [7:0]       b_i,
   input  logic             sub_i,
   output logic [ACC_W-1:0] next_acc_o,
   output logic             ovf_o
);

   logic signed [15:0]      a_ext;
   logic signed [15:0]      b_ext;
   logic signed [15:0]      prod;
   logic        [ACC_W-1:0] prod_ext;
   logic        [ACC_W-1:0] sum;

   // Full 16-bit signed product, then add or subtract it from the accumulator
   always_comb begin
      a_ext    = {{8{a_i[7]}}, a_i};
      b_ext    = {{8{b_i[7]}}, b_i};
      prod     = a_ext * b_ext;
      prod_ext = {{(ACC_W - 16){prod[15]}}, prod};
      if (sub_i) begin
         sum   = acc_i - prod_ext;
         // Subtraction overflows when operand signs differ and the result
         // sign departs from the minuend.
         ovf_o = (acc_i[ACC_W-1] != prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_i[ACC_W-1]);
      end else begin
         sum   = acc_i + prod_ext;
         ovf_o = (acc_i[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_i[ACC_W-1]);
      end
      next_acc_o = sum;
   end

endmodule

// File: rtl/mau_top.sv
// Tiny Tapeout top for a signed 8x8 multiply-accumulate unit with a 24-bit
// accumulator. Operands on ui_in, commands on uio_in, byte readback on uo_out.
module mau_top
   import mau_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [7:0]       a_q, a_d;
   logic [7:0]       b_q, b_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;

   logic [2:0]       op;
   logic             exec;
   logic [1:0]       sel;
   logic [7:0]       mac_b;
   logic             mac_sub;
   logic [ACC_W-1:0] mac_acc;
   logic             mac_ovf;
   logic [7:0]       status;
   logic             unused_bits;

   assign op          = uio_in[2:0];
   assign exec        = ena & uio_in[3];
   assign sel         = uio_in[5:4];
   assign unused_bits = &{1'b0, uio_in[7:6]};

   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

   // MACI multiplies by the incoming byte rather than the stored B
   assign mac_b   = (op == OP_MACI) ? ui_in : b_q;
   assign mac_sub = (op == OP_MSUB);

   mau_mac_unit u_mac (
      .acc_i      (acc_q),
      .a_i        (a_q),
      .b_i        (mac_b),
      .sub_i      (mac_sub),
      .next_acc_o (mac_acc),
      .ovf_o      (mac_ovf)
   );

   // Opcode decode; everything holds unless a strobed command arrives while selected
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
      ovf_d = ovf_q;
      if (exec) begin
         unique case (op)
            OP_NOP: begin
            end
            OP_LDA: a_d = ui_in;
            OP_LDB: b_d = ui_in;
            OP_MUL: begin
               // mac_unit with acc=0 would also work, but the product alone is clearer
               acc_d = mac_acc - acc_q;
               ovf_d = 1'b0;
            end
            OP_MAC, OP_MSUB: begin
               acc_d = mac_acc;
               ovf_d = ovf_q | mac_ovf;
            end
            OP_CLR: begin
               acc_d = '0;
               ovf_d = 1'b0;
            end
            OP_MACI: begin
               b_d   = ui_in;
               acc_d = mac_acc;
               ovf_d = ovf_q | mac_ovf;
            end
            default: begin
            end
         endcase
      end
   end

   // State registers with asynchronous active-low clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
         ovf_q <= ovf_d;
      end
   end

   // Status byte; ZERO is masked during reset so every select reads 0 while held
   always_comb begin
      status            = 8'h00;
      status[STAT_OVF]  = ovf_q;
      status[STAT_ZERO] = (acc_q == '0) & rst_n;
      status[STAT_NEG]  = acc_q[ACC_W-1];
   end

   // Readback mux over the registered state
   always_comb begin
      uo_out = 8'h00;
      unique case (sel)
         SEL_B0:   uo_out = acc_q[7:0];
         SEL_B1:   uo_out = acc_q[15:8];
         SEL_B2:   uo_out = acc_q[23:16];
         SEL_STAT: uo_out = status;
         default:  uo_out = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_mau_top.sv
// Directed self-checking bench for mau_top.
module tb_mau_top;
   import mau_pkg::*;

   logic       clk     = 1'b0;
   logic       clk_run = 1'b1;
   logic       rst_n   = 1'b0;
   logic       ena     = 1'b0;
   logic [7:0] ui_in   = 8'h00;
   logic [7:0] uio_in  = 8'h00;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks = 0;
   int errors = 0;

   mau_top dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   task automatic check_byte(input string tag, input logic [1:0] sel, input logic [7:0] exp);
      uio_in = {2'b00, sel, 4'b0000};
      #1;
      checks++;
      assert (uo_out === exp) else begin
         errors++;
         $error("FAIL %s sel=%0d: observed %02h expected %02h", tag, sel, uo_out, exp);
      end
      checks++;
      assert ({uio_out, uio_oe} === 16'h0000) else begin
         errors++;
         $error("FAIL %s uio: observed out=%02h oe=%02h expected 00/00", tag, uio_out, uio_oe);
      end
   endtask

   task automatic check_acc(input string tag, input logic [23:0] exp);
      check_byte(tag, SEL_B0, exp[7:0]);
      check_byte(tag, SEL_B1, exp[15:8]);
      check_byte(tag, SEL_B2, exp[23:16]);
   endtask

   task automatic cmd(input logic [2:0] op, input logic [7:0] data);
      @(negedge clk);
      ui_in  = data;
      uio_in = {2'b00, 2'b00, 1'b1, op};
      @(posedge clk);
      #1;
      uio_in = 8'h00;
   endtask

   initial begin
      // Reset held: every select reads zero
      #2;
      for (int s = 0; s < 4; s++) check_byte("reset", s[1:0], 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      ena   = 1'b1;
      check_byte("post_reset_stat", SEL_STAT, 8'h40);

      // Basic multiply
      cmd(OP_LDA, 8'h03);
      cmd(OP_LDB, 8'h05);
      cmd(OP_MUL, 8'h00);
      check_acc("mul_3x5", 24'h00000F);
      check_byte("mul_3x5_stat", SEL_STAT, 8'h00);

      // Gating: deselected, then unstrobed
      ena = 1'b0;
      cmd(OP_MAC, 8'h00);
      ena = 1'b1;
      check_acc("gate_ena", 24'h00000F);
      @(negedge clk);
      uio_in = {2'b00, 2'b00, 1'b0, OP_MAC};
      @(posedge clk);
      #1;
      uio_in = 8'h00;
      check_acc("gate_valid", 24'h00000F);

      // Signed path
      cmd(OP_LDA, 8'h80);
      cmd(OP_LDB, 8'h80);
      cmd(OP_MUL, 8'h00);
      check_acc("mul_neg", 24'h004000);
      cmd(OP_MAC, 8'h00);
      check_acc("mac_neg", 24'h008000);
      cmd(OP_MSUB, 8'h00);
      check_acc("msub1", 24'h004000);
      cmd(OP_MSUB, 8'h00);
      check_acc("msub2", 24'h000000);
      check_byte("msub2_stat", SEL_STAT, 8'h40);

      // Stream op uses the incoming byte and stores it in B
      cmd(OP_CLR, 8'h00);
      cmd(OP_LDA, 8'hFF);
      cmd(OP_MACI, 8'h02);
      check_acc("maci", 24'hFFFFFE);
      check_byte("maci_stat", SEL_STAT, 8'h20);
      cmd(OP_MAC, 8'h00);
      check_acc("maci_b_loaded", 24'hFFFFFC);

      // Overflow
      cmd(OP_LDA, 8'h7F);
      cmd(OP_LDB, 8'h7F);
      cmd(OP_MUL, 8'h00);
      check_acc("mul_7f", 24'h003F01);
      for (int i = 0; i < 519; i++) cmd(OP_MAC, 8'h00);
      check_acc("mac_519", 24'h7FFA08);
      check_byte("mac_519_stat", SEL_STAT, 8'h00);
      cmd(OP_MAC, 8'h00);
      check_acc("mac_ovf", 24'h803909);
      check_byte("mac_ovf_stat", SEL_STAT, 8'hA0);
      cmd(OP_MAC, 8'h00);
      check_acc("mac_sticky", 24'h80780A);
      check_byte("mac_sticky_stat", SEL_STAT, 8'hA0);
      cmd(OP_CLR, 8'h00);
      check_byte("clr_stat", SEL_STAT, 8'h40);
      cmd(OP_MAC, 8'h00);
      check_acc("clr_keeps_ab", 24'h003F01);

      // Asynchronous reset with the clock stopped
      @(negedge clk);
      clk_run = 1'b0;
      #3;
      rst_n = 1'b0;
      check_acc("async_reset", 24'h000000);
      check_byte("async_reset_stat", SEL_STAT, 8'h00);
      rst_n = 1'b1;
      check_byte("after_reset_stat", SEL_STAT, 8'h40);
      clk_run = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
